// File: rtl/superga_timing_pkg.sv
// superga_timing_pkg
//   Shared raster timing defaults for the scan generator and the DAC/output
//   stage: active/porch/sync sizes, derived totals, counter widths, the
//   sync polarity and the reset value of the zoom factor.
//   Ports: none (package).
package superga_timing_pkg;

  localparam int DEF_PIX_DIV  = 2;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 16;

  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 15;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync level that means "asserted"; 0 gives active-low sync pulses.
  localparam logic       DEF_SYNC_POL = 1'b0;
  localparam logic [7:0] DEF_ZOOM_RST = 8'd1;

  // Counter width for a range of n values; a single-value range still
  // needs one bit so the register exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_H_W = cnt_width(DEF_H_TOTAL);
  localparam int DEF_V_W = cnt_width(DEF_V_TOTAL);

endpackage

// File: rtl/scan_counter.sv
// scan_counter
//   Wrapping up-counter with enable and a programmable terminal count.
//   Counts 0..last, wraps to 0, and flags the wrapping cycle on carry.
//   Ports:
//     clk   - clock
//     rst   - asynchronous reset, active-high (count returns to 0)
//     en    - advance the count this cycle
//     last  - terminal count value
//     count - current count
//     carry - en && count==last, i.e. the count wraps on this edge
module scan_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         carry
);

  assign carry = en && (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= (count == last) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/scan_gen.sv
// scan_gen
//   Raster scan generator. Divides ACLK into pixel slots, walks h/v counters
//   through active, front porch, sync and back porch regions, and emits
//   registered active-area coordinates, strobes, sync and a frame-stable zoom.
//   Ports:
//     ACLK       - system clock
//     ARESET     - asynchronous reset, active-high
//     Enable     - run; low freezes the scan position
//     ZoomIn     - requested zoom, captured only at frame start
//     Xcoord     - active-area column (0 outside the active area)
//     Ycoord     - active-area row (0 outside the active area)
//     Zoom       - zoom factor held constant for a whole frame
//     CoordValid - Xcoord/Ycoord are inside the active area
//     PixCe      - strobe on the first cycle of each pixel slot
//     LineStart  - PixCe at h==0
//     FrameStart - PixCe at h==0 && v==0
//     HSync      - horizontal sync
//     VSync      - vertical sync
module scan_gen
  import superga_timing_pkg::*;
#(
  parameter int         PIX_DIV  = DEF_PIX_DIV,
  parameter int         H_ACTIVE = DEF_H_ACTIVE,
  parameter int         H_FP     = DEF_H_FP,
  parameter int         H_SYNC   = DEF_H_SYNC,
  parameter int         H_BP     = DEF_H_BP,
  parameter int         V_ACTIVE = DEF_V_ACTIVE,
  parameter int         V_FP     = DEF_V_FP,
  parameter int         V_SYNC   = DEF_V_SYNC,
  parameter int         V_BP     = DEF_V_BP,
  parameter logic       SYNC_POL = DEF_SYNC_POL,
  parameter logic [7:0] ZOOM_RST = DEF_ZOOM_RST
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       Enable,
  input  logic [7:0] ZoomIn,
  output logic [7:0] Xcoord,
  output logic [7:0] Ycoord,
  output logic [7:0] Zoom,
  output logic       CoordValid,
  output logic       PixCe,
  output logic       LineStart,
  output logic       FrameStart,
  output logic       HSync,
  output logic       VSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = cnt_width(PIX_DIV);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  // One spare bit so region bounds equal to the total still fit.
  localparam int HX      = HW + 1;
  localparam int VX      = VW + 1;

  localparam logic [PW-1:0] P_LAST = PW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);

  // Coordinates are 8 bits wide; a larger active area would alias.
  if (H_ACTIVE > 256 || V_ACTIVE > 256) begin : g_active_too_big
    $error("scan_gen: H_ACTIVE and V_ACTIVE must not exceed 256");
  end
  if (PIX_DIV < 1) begin : g_pix_div_bad
    $error("scan_gen: PIX_DIV must be at least 1");
  end

  logic [PW-1:0] p;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          p_carry;
  logic          h_carry;
  logic          v_carry;

  // Cascade: p advances while enabled, h on each pixel-slot wrap, v on each
  // line wrap. With PIX_DIV=1 p stays 0 and p_carry equals Enable.
  scan_counter #(.W(PW)) u_pix (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (Enable),
    .last  (P_LAST),
    .count (p),
    .carry (p_carry)
  );

  scan_counter #(.W(HW)) u_hor (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (p_carry),
    .last  (H_LAST),
    .count (h),
    .carry (h_carry)
  );

  scan_counter #(.W(VW)) u_ver (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (h_carry),
    .last  (V_LAST),
    .count (v),
    .carry (v_carry)
  );

  // A frame can only wrap on the last pixel slot of a line.
  a_frame_wrap : assert property (@(posedge ACLK) disable iff (ARESET)
    v_carry |-> (h_carry && p_carry));

  logic [HX-1:0] hx;
  logic [VX-1:0] vx;
  logic          act;
  logic          slot0;
  logic          hs_on;
  logic          vs_on;

  assign hx    = {1'b0, h};
  assign vx    = {1'b0, v};
  assign act   = (hx < H_ACT_END) && (vx < V_ACT_END);
  assign slot0 = Enable && (p == '0);
  assign hs_on = (hx >= H_SYNC_BEG) && (hx < H_SYNC_END);
  // v only moves when h wraps, so VSync can only change at a line boundary.
  assign vs_on = (vx >= V_SYNC_BEG) && (vx < V_SYNC_END);

  // Strobes and CoordValid drop while disabled; coordinates, syncs and Zoom
  // keep their last values so the downstream pipe sees a stable picture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      Xcoord     <= 8'd0;
      Ycoord     <= 8'd0;
      Zoom       <= ZOOM_RST;
      CoordValid <= 1'b0;
      PixCe      <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      HSync      <= ~SYNC_POL;
      VSync      <= ~SYNC_POL;
    end else begin
      CoordValid <= Enable && act;
      PixCe      <= slot0;
      LineStart  <= slot0 && (h == '0);
      FrameStart <= slot0 && (h == '0) && (v == '0);
      if (Enable) begin
        Xcoord <= act ? 8'(h) : 8'd0;
        Ycoord <= act ? 8'(v) : 8'd0;
        HSync  <= hs_on ? SYNC_POL : ~SYNC_POL;
        VSync  <= vs_on ? SYNC_POL : ~SYNC_POL;
      end
      if (slot0 && (h == '0) && (v == '0)) begin
        Zoom <= ZoomIn;
      end
    end
  end

endmodule

// File: tb/tb_scan_gen.sv
// tb_scan_gen
//   Self-checking bench for scan_gen. Three instances share the stimulus:
//   the default timing, a small PIX_DIV=3 raster with active-high sync, and
//   a small PIX_DIV=1 raster. A reference model derives the expected outputs
//   from the count of enabled cycles since reset with plain division/modulo.
`timescale 1ns/1ps
module tb_scan_gen;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] zoom;
    logic       cv;
    logic       pce;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
  } obs_t;

  typedef struct {
    int         div;
    int         ha, hfp, hs, hbp;
    int         va, vfp, vs, vbp;
    logic       pol;
    logic [7:0] zrst;
  } cfg_t;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       Enable = 1'b0;
  logic [7:0] ZoomIn = 8'd0;

  always #5 ACLK = ~ACLK;

  logic [7:0] x0, y0, z0, x1, y1, z1, x2, y2, z2;
  logic       cv0, pc0, ls0, fs0, hs0, vs0;
  logic       cv1, pc1, ls1, fs1, hs1, vs1;
  logic       cv2, pc2, ls2, fs2, hs2, vs2;

  scan_gen dut_def (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable), .ZoomIn(ZoomIn),
    .Xcoord(x0), .Ycoord(y0), .Zoom(z0), .CoordValid(cv0), .PixCe(pc0),
    .LineStart(ls0), .FrameStart(fs0), .HSync(hs0), .VSync(vs0)
  );

  scan_gen #(
    .PIX_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .SYNC_POL(1'b1), .ZOOM_RST(8'h5A)
  ) dut_small (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable), .ZoomIn(ZoomIn),
    .Xcoord(x1), .Ycoord(y1), .Zoom(z1), .CoordValid(cv1), .PixCe(pc1),
    .LineStart(ls1), .FrameStart(fs1), .HSync(hs1), .VSync(vs1)
  );

  scan_gen #(
    .PIX_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_one (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable), .ZoomIn(ZoomIn),
    .Xcoord(x2), .Ycoord(y2), .Zoom(z2), .CoordValid(cv2), .PixCe(pc2),
    .LineStart(ls2), .FrameStart(fs2), .HSync(hs2), .VSync(vs2)
  );

  obs_t o [3];
  assign o[0] = {x0, y0, z0, cv0, pc0, ls0, fs0, hs0, vs0};
  assign o[1] = {x1, y1, z1, cv1, pc1, ls1, fs1, hs1, vs1};
  assign o[2] = {x2, y2, z2, cv2, pc2, ls2, fs2, hs2, vs2};

  cfg_t   cfg [3];
  obs_t   e   [3];
  string  names [3] = '{"def", "small", "one"};
  longint t;
  int     checks   = 0;
  int     failures = 0;

  // Expected outputs after one clock edge, given the scan position t
  // (enabled cycles since reset) before that edge.
  function automatic obs_t predict(input cfg_t c, input longint pos, input logic en,
                                   input obs_t prev, input logic [7:0] zin);
    obs_t   r;
    longint htot, vtot, tt;
    int     p, h, v;
    logic   act;
    r = prev;
    if (!en) begin
      r.cv  = 1'b0;
      r.pce = 1'b0;
      r.ls  = 1'b0;
      r.fs  = 1'b0;
      return r;
    end
    htot = longint'(c.ha + c.hfp + c.hs + c.hbp);
    vtot = longint'(c.va + c.vfp + c.vs + c.vbp);
    tt   = pos % (longint'(c.div) * htot * vtot);
    p    = int'(tt % longint'(c.div));
    h    = int'((tt / longint'(c.div)) % htot);
    v    = int'(tt / (longint'(c.div) * htot));
    act  = (h < c.ha) && (v < c.va);
    r.cv  = act;
    r.pce = (p == 0);
    r.ls  = (p == 0) && (h == 0);
    r.fs  = (p == 0) && (h == 0) && (v == 0);
    r.x   = act ? 8'(h) : 8'd0;
    r.y   = act ? 8'(v) : 8'd0;
    r.hs  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
    r.vs  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
    if (r.fs) r.zoom = zin;
    return r;
  endfunction

  function automatic obs_t resetExp(input cfg_t c);
    obs_t r;
    r      = '0;
    r.zoom = c.zrst;
    r.hs   = ~c.pol;
    r.vs   = ~c.pol;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, expv);
    end
  endtask

  task automatic checkInst(input int i);
    checkOutput({names[i], ".x"},    o[i].x,    e[i].x);
    checkOutput({names[i], ".y"},    o[i].y,    e[i].y);
    checkOutput({names[i], ".zoom"}, o[i].zoom, e[i].zoom);
    checkOutput({names[i], ".cv"},   8'(o[i].cv),  8'(e[i].cv));
    checkOutput({names[i], ".pce"},  8'(o[i].pce), 8'(e[i].pce));
    checkOutput({names[i], ".ls"},   8'(o[i].ls),  8'(e[i].ls));
    checkOutput({names[i], ".fs"},   8'(o[i].fs),  8'(e[i].fs));
    checkOutput({names[i], ".hs"},   8'(o[i].hs),  8'(e[i].hs));
    checkOutput({names[i], ".vs"},   8'(o[i].vs),  8'(e[i].vs));
  endtask

  // One clock: drive inputs at the falling edge, step the model on the
  // rising edge, compare at the next falling edge.
  task automatic applyStimulus(input logic en, input logic [7:0] zin);
    Enable = en;
    ZoomIn = zin;
    @(posedge ACLK);
    for (int k = 0; k < 3; k++) e[k] = predict(cfg[k], t, en, e[k], zin);
    if (en) t++;
    @(negedge ACLK);
    for (int k = 0; k < 3; k++) checkInst(k);
  endtask

  // Reset in the middle of the clock-low phase and check the outputs
  // before any clock edge arrives, then release on a falling edge.
  task automatic asyncReset();
    #2;
    ARESET = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      e[k] = resetExp(cfg[k]);
      checkInst(k);
    end
    t = 0;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    cfg[0] = '{2, 256, 16, 32, 16, 240, 3, 4, 15, 1'b0, 8'd1};
    cfg[1] = '{3, 20, 3, 5, 4, 6, 2, 3, 2, 1'b1, 8'h5A};
    cfg[2] = '{1, 16, 2, 4, 2, 5, 1, 2, 1, 1'b0, 8'd1};
    t = 0;

    repeat (2) @(negedge ACLK);
    for (int k = 0; k < 3; k++) begin
      e[k] = resetExp(cfg[k]);
      checkInst(k);
    end
    checkOutput("def.zoom_rst", o[0].zoom, 8'd1);
    ARESET = 1'b0;

    // Continuous run with one 10-cycle Enable gap at X=100; ZoomIn moves
    // from 1 to 4 partway through.
    for (int i = 0; i < 2700; i++) begin
      applyStimulus(!(i >= 201 && i < 211), (i < 600) ? 8'd1 : 8'd4);
      if (i == 0) begin
        checkOutput("def.first_x",  o[0].x, 8'd0);
        checkOutput("def.first_fs", 8'(o[0].fs), 8'd1);
        checkOutput("def.first_cv", 8'(o[0].cv), 8'd1);
        checkOutput("one.first_pce", 8'(o[2].pce), 8'd1);
      end
      if (i == 1) checkOutput("def.pce_gap", 8'(o[0].pce), 8'd0);
      if (i == 2) checkOutput("def.x1_at3", o[0].x, 8'd1);
      if (i == 3) checkOutput("one.pce_each", 8'(o[2].pce), 8'd1);
      if (i == 205) begin
        checkOutput("def.hold_x", o[0].x, 8'd100);
        checkOutput("def.hold_cv", 8'(o[0].cv), 8'd0);
        checkOutput("def.hold_pce", 8'(o[0].pce), 8'd0);
      end
      if (i == 211) checkOutput("def.resume_x", o[0].x, 8'd100);
      if (i == 212) checkOutput("def.next_x", o[0].x, 8'd101);
      if (i == 521) checkOutput("def.last_cv", 8'(o[0].cv), 8'd1);
      if (i == 522) checkOutput("def.cv_fall", 8'(o[0].cv), 8'd0);
      if (i == 553) checkOutput("def.hs_pre", 8'(o[0].hs), 8'd1);
      if (i == 554) checkOutput("def.hs_low", 8'(o[0].hs), 8'd0);
      if (i == 650) checkOutput("def.line2", 8'(o[0].ls), 8'd1);
      if (i == 1000) begin
        checkOutput("def.zoom_held", o[0].zoom, 8'd1);
        checkOutput("one.zoom_new", o[2].zoom, 8'd4);
      end
    end

    // Random run, reset mid-stream, then random Enable/ZoomIn.
    for (int i = 0; i < int'($urandom_range(50, 400)); i++)
      applyStimulus(1'b1, 8'($urandom));
    asyncReset();
    applyStimulus(1'b1, 8'h33);
    checkOutput("def.restart_fs", 8'(o[0].fs), 8'd1);
    checkOutput("def.restart_zoom", o[0].zoom, 8'h33);
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 9) != 0, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
